// File: rtl/mem_port_arbiter.sv
// Arbiter for a single-ported unified memory shared by instruction fetch (IF) and the data (MEM-stage) port.
// Build option: define MEM_ARB_STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  state_t     state;
  owner_t     owner;
  logic       op_we;
  logic [3:0] wait_cnt;
  logic       grant_d;
  logic       grant_i;
  logic       to_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt;
  logic            starve_hit;

  // Once IF has watched STARVE_LIMIT data grants go by, it takes the next slot.
  assign starve_hit = if_req && (starve_cnt == SC_W'(STARVE_LIMIT));
  assign grant_d    = dm_req && !starve_hit;
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_LIMIT > 0);
  assign grant_d           = dm_req;
`endif

  // Data wins ties: it belongs to the older instruction in the pipeline.
  assign grant_i = if_req && !grant_d;

  assign to_done = ((state == ISSUE) && (MEM_LATENCY == 1)) ||
                   ((state == WAIT) && (wait_cnt == 4'd1));

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;
  assign busy      = (state != IDLE);

  logic unused_addr_hi;
  assign unused_addr_hi = ^{if_addr, dm_addr};

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= OWN_I;
      op_we     <= 1'b0;
      wait_cnt  <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      starve_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking defaults make strobes one-cycle pulses; a later assignment in this block overrides them.
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            owner    <= grant_d ? OWN_D : OWN_I;
            op_we    <= grant_d && dm_we;
            mem_en   <= 1'b1;
            mem_we   <= grant_d && dm_we;
            mem_addr <= grant_d ? dm_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
            if (grant_d) mem_wdata <= dm_wdata;
            state    <= ISSUE;
          end
`ifdef MEM_ARB_STARVE_GUARD_EN
          if (!if_req || grant_i) starve_cnt <= '0;
          else if (grant_d)       starve_cnt <= starve_cnt + 1'b1;
`endif
        end
        ISSUE: begin
          wait_cnt <= LAT_M1;
          if (!to_done) state <= WAIT;
        end
        WAIT:    wait_cnt <= wait_cnt - 4'd1;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // Read data is captured on the same edge that enters DONE; writes leave dm_rdata alone.
      if (to_done) begin
        state <= DONE;
        if (owner == OWN_D) begin
          dm_ready <= 1'b1;
          if (!op_we) dm_rdata <= mem_rdata;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule
